// File: rtl/pipelined_cond_sum_adder.sv
// rtl/pipelined_cond_sum_adder.sv - two-stage conditional-sum adder/subtractor with valid/ready flow control
module pipelined_cond_sum_adder #(
   parameter int N = 64,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         cout,
   output logic         ovf
);

   localparam int C = N / K;

   logic         adv1, adv2;
   logic         s1_valid, s2_valid;
   logic [N-1:0] b_eff;
   logic [N-1:0] pre_sum0, pre_sum1;
   logic [C-1:0] pre_cout0, pre_cout1;

   logic [N-1:0] s1_sum0, s1_sum1;
   logic [C-1:0] s1_cout0, s1_cout1;
   logic         s1_c0, s1_a_msb, s1_b_msb;

   logic [N-1:0] res;
   logic         res_carry, res_ovf;

   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   assign b_eff = sub ? ~b : b;

   // Each chunk is summed twice, once per possible carry-in, so stage 2 only has to select.
   for (genvar i = 0; i < C; i++) begin : g_chunk
      logic [K:0] t0, t1;
      assign t0 = {1'b0, a[i*K +: K]} + {1'b0, b_eff[i*K +: K]};
      assign t1 = t0 + {{K{1'b0}}, 1'b1};
      assign pre_sum0[i*K +: K] = t0[K-1:0];
      assign pre_sum1[i*K +: K] = t1[K-1:0];
      assign pre_cout0[i]       = t0[K];
      assign pre_cout1[i]       = t1[K];
   end

   always_comb begin
      res       = '0;
      res_carry = s1_c0;
      for (int i = 0; i < C; i++) begin
         if (res_carry) begin
            res[i*K +: K] = s1_sum1[i*K +: K];
            res_carry     = s1_cout1[i];
         end else begin
            res[i*K +: K] = s1_sum0[i*K +: K];
            res_carry     = s1_cout0[i];
         end
      end
      res_ovf = (s1_a_msb == s1_b_msb) && (res[N-1] != s1_a_msb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (adv1) s1_valid <= in_valid;
         if (adv2) s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum0  <= '0;
         s1_sum1  <= '0;
         s1_cout0 <= '0;
         s1_cout1 <= '0;
         s1_c0    <= 1'b0;
         s1_a_msb <= 1'b0;
         s1_b_msb <= 1'b0;
      end else if (adv1 && in_valid) begin
         s1_sum0  <= pre_sum0;
         s1_sum1  <= pre_sum1;
         s1_cout0 <= pre_cout0;
         s1_cout1 <= pre_cout1;
         s1_c0    <= sub | cin;
         s1_a_msb <= a[N-1];
         s1_b_msb <= b_eff[N-1];
      end
   end

   // Result registers only move when a real beat advances, so y holds through stalls and bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y    <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (adv2 && s1_valid) begin
         y    <= res;
         cout <= res_carry;
         ovf  <= res_ovf;
      end
   end

endmodule

// File: tb/tb_pipelined_cond_sum_adder.sv
// tb/tb_pipelined_cond_sum_adder.sv - self-checking bench: vector table, flow-control sequences, random scoreboard
module tb_pipelined_cond_sum_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [63:0] a, b;
   logic        cin, sub;

   logic        in_ready, out_valid, cout, ovf;
   logic [63:0] y;
   logic        in_ready16, out_valid16, cout16, ovf16;
   logic [15:0] y16;
   logic        in_ready8, out_valid8, cout8, ovf8;
   logic [7:0]  y8;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [63:0] a, b;
      logic        cin, sub;
      logic [63:0] y;
      logic        cout, ovf;
   } vec_t;

   typedef struct {
      logic [63:0] a, b;
      logic        cin, sub;
   } beat_t;

   vec_t  vecs[9];
   beat_t q[$];

   always #5 clk = ~clk;

   pipelined_cond_sum_adder #(.N(64), .K(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .cout(cout), .ovf(ovf)
   );

   pipelined_cond_sum_adder #(.N(16), .K(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(out_valid16),
      .out_ready(out_ready), .y(y16), .cout(cout16), .ovf(ovf16)
   );

   pipelined_cond_sum_adder #(.N(8), .K(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid8),
      .out_ready(out_ready), .y(y8), .cout(cout8), .ovf(ovf8)
   );

   // Plain w-bit two's-complement arithmetic: returns {ovf, cout, y}.
   function automatic logic [65:0] model(input logic [63:0] aa, input logic [63:0] bb,
                                         input logic c, input logic s, input int w);
      logic [64:0] mask, am, bm, sum;
      mask = (65'd1 << w) - 65'd1;
      am   = {1'b0, aa} & mask;
      bm   = (s ? ~{1'b0, bb} : {1'b0, bb}) & mask;
      sum  = am + bm + {64'd0, (s | c)};
      return {(am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]), sum[w], sum[63:0] & mask[63:0]};
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                        input logic c, input logic s);
      in_valid = v;
      a = aa;
      b = bb;
      cin = c;
      sub = s;
   endtask

   // One random-phase cycle: inputs already driven, sample mid-cycle.
   task automatic step();
      logic [65:0] e;
      beat_t       h;
      #1;
      check("in_ready", {in_ready, in_ready16, in_ready8},
            {3{(q.size() < 2) || out_ready}});
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("spurious_out", 80'(out_valid), 80'(0));
         end else begin
            h = q.pop_front();
            e = model(h.a, h.b, h.cin, h.sub, 64);
            check("rand64", {ovf, cout, y}, 80'(e));
            e = model(h.a, h.b, h.cin, h.sub, 16);
            check("rand16", {ovf16, cout16, y16}, {e[65:64], e[15:0]});
            e = model(h.a, h.b, h.cin, h.sub, 8);
            check("rand8", {ovf8, cout8, y8}, {e[65:64], e[7:0]});
         end
      end
      if (in_valid && in_ready) q.push_back('{a, b, cin, sub});
      @(negedge clk);
   endtask

   function automatic logic [63:0] rand64();
      case ($urandom_range(7))
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         1: return 64'h8000_0000_0000_0000;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'(0);
         default: return {$urandom, $urandom};
      endcase
   endfunction

   logic [65:0] ea, eb, ec;

   initial begin
      vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
      vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[2] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[3] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{64'h0000_0000_0000_00FF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0000_0100, 1'b0, 1'b0};
      vecs[6] = '{64'h00FF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h0100_0000_0000_0001, 1'b0, 1'b0};
      vecs[7] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      #1 check("reset_state", {in_ready, out_valid, ovf, cout, y}, {2'b10, 2'b00, 64'd0});
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         #1 check($sformatf("vec%0d_lat1", i), 80'(out_valid), 80'(0));
         @(negedge clk);
         #1 check($sformatf("vec%0d", i), {out_valid, ovf, cout, y},
                  {1'b1, vecs[i].ovf, vecs[i].cout, vecs[i].y});
      end

      // Backpressure: three beats with the sink stalled.
      ea = model(64'd100, 64'd23, 1'b1, 1'b0, 64);
      eb = model(64'd100, 64'd23, 1'b0, 1'b1, 64);
      ec = model(64'hDEAD_BEEF_0000_0001, 64'h1234, 1'b0, 1'b0, 64);
      @(negedge clk);
      out_ready = 1'b0;
      drive(1, 64'd100, 64'd23, 1'b1, 1'b0);
      #1 check("bp_ready0", 80'(in_ready), 80'(1));
      @(negedge clk);
      drive(1, 64'd100, 64'd23, 1'b0, 1'b1);
      #1 check("bp_ready1", 80'(in_ready), 80'(1));
      @(negedge clk);
      drive(1, 64'hDEAD_BEEF_0000_0001, 64'h1234, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("bp_stall%0d", k), {in_ready, out_valid, ovf, cout, y}, {2'b01, ea});
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("bp_release", {in_ready, out_valid, ovf, cout, y}, {2'b11, ea});
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      #1 check("bp_second", {out_valid, ovf, cout, y}, {1'b1, eb});
      @(negedge clk);
      #1 check("bp_third", {out_valid, ovf, cout, y}, {1'b1, ec});
      @(negedge clk);
      #1 check("bp_empty", 80'(out_valid), 80'(0));

      // Reset with two beats in flight.
      @(negedge clk);
      out_ready = 1'b0;
      drive(1, 64'd1, 64'd2, 1'b0, 1'b0);
      @(negedge clk);
      drive(1, 64'd3, 64'd4, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      #1 check("rst_full", {in_ready, out_valid}, {2'b01});
      rst_n = 1'b0;
      #1 check("rst_async", {in_ready, out_valid, ovf, cout, y}, {2'b10, 2'b00, 64'd0});
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1, 64'd40, 64'd2, 1'b0, 1'b1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      #1 check("rst_no_stale", 80'(out_valid), 80'(0));
      @(negedge clk);
      #1 check("rst_first", {out_valid, ovf, cout, y}, {1'b1, model(64'd40, 64'd2, 1'b0, 1'b1, 64)});
      @(negedge clk);
      #1 check("rst_after", 80'(out_valid), 80'(0));

      // Random traffic against the scoreboard, then drain.
      q.delete();
      @(negedge clk);
      for (int n = 0; n < 20000; n++) begin
         drive(1'($urandom_range(3) != 0), rand64(), rand64(), 1'($urandom), 1'($urandom));
         out_ready = 1'($urandom_range(3) != 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) step();
      #1 check("drain_empty", {79'(q.size()), out_valid}, 80'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
